// File: rtl/lsu_ctrl.sv
// Multi-cycle RV32I load/store initiator for a word-addressed data memory.
// Sub-word stores are performed as read-modify-write of the containing word.
module lsu_ctrl #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int unsigned AW = 32;
  localparam int unsigned WIDX_W = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     f3_q, f3_d;
  logic [1:0]     addr_lo_q, addr_lo_d;
  logic [15:0]    wdata_lo_q, wdata_lo_d;
  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_a_q, mem_a_d;
  logic [31:0]    mem_wd_q, mem_wd_d;

  logic           illegal, misaligned, out_of_range, req_err;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_data;
  logic [31:0]    merged;

  // Request legality, evaluated on the live request while idle
  always_comb begin
    if (req_we) illegal = (req_funct3 > 3'd2);
    else        illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= WIDX_W'(MEM_WORDS));
    req_err      = illegal || misaligned || out_of_range;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    ld_byte = mem_rd[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rd;
    endcase
    merged = mem_rd;
    if (f3_q[0]) begin
      if (addr_lo_q[1]) merged[31:16] = wdata_lo_q;
      else              merged[15:0]  = wdata_lo_q;
    end else begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_lo_q[7:0];
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    wdata_lo_d   = wdata_lo_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    mem_we_d     = 1'b0;
    mem_a_d      = '0;
    mem_wd_d     = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d       = req_funct3;
          addr_lo_d  = req_addr[1:0];
          wdata_lo_d = req_wdata[15:0];
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_a_d = {req_addr[31:2], 2'b00};
            if (!req_we) begin
              state_d = S_LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state_d  = S_WRITE;
              mem_we_d = 1'b1;
              mem_wd_d = req_wdata;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_LOAD: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      S_RMW_RD: begin
        state_d  = S_WRITE;
        mem_a_d  = mem_a_q;
        mem_we_d = 1'b1;
        mem_wd_d = merged;
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'b000;
      addr_lo_q    <= 2'b00;
      wdata_lo_q   <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_lo_q   <= wdata_lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  // Reset in the WRITE cycle must suppress the write on that same edge
  assign mem_we     = mem_we_q & ~reset;
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl with a byte-level reference model
// and a behavioural data memory.
module tb_lsu_ctrl;

  localparam int unsigned MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        tb_init = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 3) return 32'h8899AABB;
    return 32'h13579BDF ^ (32'(i) * 32'h01010101);
  endfunction

  assign mem_rd = dmem[mem_a[7:2]];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) dmem[i] <= init_word(i);
    end else if (mem_we) begin
      dmem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular view of memory, computed from access size and offset
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int unsigned size, off, idx;
    logic legal;
    logic [31:0] v, mask, w;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err   = !legal || ((addr % size) != 0) || ((addr / 4) >= MEM_WORDS);
    rdata = 32'h0;
    if (!err) begin
      idx = addr / 4;
      off = addr % 4;
      if (!we) begin
        v    = ref_mem[idx] >> (8 * off);
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFFFFFF;
        v    = v & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        rdata = v;
      end else begin
        w = ref_mem[idx];
        for (int i = 0; i < int'(size); i++) w[8*(int'(off)+i) +: 8] = wdata[8*i +: 8];
        ref_mem[idx] = w;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit keep,
                        output logic [31:0] got_rdata, output logic got_err);
    logic exp_err;
    logic [31:0] exp_rdata, exp_a;
    int lat, w;
    model_req(we, f3, addr, wdata, exp_err, exp_rdata);
    lat = exp_err ? 1 : (!we || f3 == 3'd2) ? 2 : 3;
    got_rdata = 32'h0;
    got_err   = 1'b0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    check32("ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid  = keep;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      exp_a = (k < lat && !exp_err) ? {addr[31:2], 2'b00} : 32'h0;
      check32("resp_valid", 32'(resp_valid), 32'(k == lat));
      check32("mem_we", 32'(mem_we), 32'(we && !exp_err && k == lat - 1));
      check32("mem_a", mem_a, exp_a);
      check32("ready_busy", 32'(req_ready), 32'd0);
      if (k == lat) begin
        got_rdata = resp_rdata;
        got_err   = resp_err;
        check32("resp_rdata", resp_rdata, exp_rdata);
        check32("resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
    if ((addr / 4) < MEM_WORDS) check32("mem_word", dmem[addr[7:2]], ref_mem[addr[7:2]]);
  endtask

  // Store request aborted by reset asserted in cycle abort_k after acceptance
  task automatic abort_req(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int abort_k);
    @(negedge clk);
    check32("abort_ready", 32'(req_ready), 32'd1);
    req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int k = 1; k <= abort_k; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      check32("abort_mem_we_pre", 32'(mem_we), 32'(k == 2));
    end
    reset = 1'b1;
    #1;
    check32("abort_mem_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check32("abort_ready_after", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check32("abort_no_resp", 32'(resp_valid), 32'd0);
      check32("abort_no_we", 32'(mem_we), 32'd0);
      @(negedge clk);
    end
    check32("abort_mem_word", dmem[addr[7:2]], ref_mem[addr[7:2]]);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] addr;
    bit          keep;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    check32("rst_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_resp_err", 32'(resp_err), 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    check32("rst_mem_a", mem_a, 32'h0);
    check32("rst_mem_wd", mem_wd, 32'h0);
    reset = 1'b0;
    tb_init = 1'b0;
    @(negedge clk);
    check32("rst_ready", 32'(req_ready), 32'd1);

    do_req(1'b0, 3'b000, 32'h0000000D, $urandom, 1'b0, r, e);
    check32("lb_rdata", r, 32'hFFFFFFAA);
    check32("lb_err", 32'(e), 32'd0);
    do_req(1'b0, 3'b101, 32'h0000000E, $urandom, 1'b0, r, e);
    check32("lhu_rdata", r, 32'h00008899);
    do_req(1'b0, 3'b010, 32'h0000000C, $urandom, 1'b0, r, e);
    check32("lw_rdata", r, 32'h8899AABB);
    do_req(1'b1, 3'b000, 32'h0000000C, 32'h00000055, 1'b0, r, e);
    check32("sb_rdata", r, 32'h0);
    check32("sb_word3", dmem[3], 32'h8899AA55);
    do_req(1'b0, 3'b010, 32'h00000006, $urandom, 1'b0, r, e);
    check32("lw_misalign_err", 32'(e), 32'd1);
    check32("lw_misalign_rdata", r, 32'h0);
    do_req(1'b1, 3'b001, 32'h00000101, $urandom, 1'b0, r, e);
    check32("sh_misalign_err", 32'(e), 32'd1);
    do_req(1'b0, 3'b010, 32'h00000100, $urandom, 1'b0, r, e);
    check32("lw_range_err", 32'(e), 32'd1);
    do_req(1'b1, 3'b010, 32'h00000010, 32'h12345678, 1'b1, r, e);
    do_req(1'b0, 3'b010, 32'h00000010, $urandom, 1'b0, r, e);
    check32("b2b_lw_rdata", r, 32'h12345678);
    abort_req(3'b001, 32'h00000012, 32'h0000BEEF, 1);
    check32("abort_sh_word4", dmem[4], 32'h12345678);
    abort_req(3'b000, 32'h0000000C, 32'h000000EE, 2);
    check32("abort_sb_word3", dmem[3], 32'h8899AA55);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = $urandom_range(0, MEM_WORDS * 4 + 15);
      keep = (i < 299) && ($urandom_range(0, 3) == 0);
      do_req(1'($urandom), 3'($urandom), addr, $urandom, keep, r, e);
    end
    @(negedge clk);
    req_valid = 1'b0;

    for (int i = 0; i < int'(MEM_WORDS); i++) check32("final_mem", dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store initiator that drives the word-addressed data memory (combinational read, synchronous word write, no byte enables).
- Accepts one load/store request at a time from the core datapath.
- Performs RV32I byte, halfword and word access and sign/zero extension.
- Sub-word stores are done as read-modify-write. Misaligned, illegal and out-of-range accesses are flagged.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in data memory; valid word index is addr[31:2] < MEM_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (low byte or halfword used for SB/SH).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; misaligned, illegal funct3 or out of range.
- mem_we  output  1  data memory write enable.
- mem_a  output  32  data memory byte address, always word aligned.
- mem_wd  output  32  data memory write data.
- mem_rd  input  32  data memory read data (combinational on mem_a).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset state:
  - state = IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0.
  - mem_we = 0; mem_a = 0; mem_wd = 0; req_ready = 1 in the cycle after reset.
- Handshake:
  - Request accepted on a rising edge with req_valid && req_ready.
  - All req_* fields are latched on acceptance; later changes have no effect.
  - No response backpressure: resp_valid pulses exactly one cycle.
- States:
  - IDLE → LOAD, for a legal load.
  - IDLE → WRITE, for SW.
  - IDLE → RMW_RD, for SB or SH.
  - IDLE → RESP, with error.
  - LOAD → RESP; RMW_RD → WRITE; WRITE → RESP; RESP → IDLE.
- Latency, acceptance edge = cycle 0; resp_valid is high in:
  - cycle 2 for loads and SW;
  - cycle 3 for SB and SH;
  - cycle 1 for errors.
- req_ready = 1 only in IDLE. A new request can be accepted in the IDLE cycle after RESP.
- mem_a:
  - {addr[31:2], 2'b00} in LOAD, RMW_RD and WRITE;
  - 0 in IDLE and RESP.
- mem_we:
  - 1 only in WRITE, gated by !reset;
  - never asserted for an erroring request.
- LOAD: mem_rd is sampled at the end of the LOAD cycle.
  - Byte lane selected by addr[1:0]; halfword lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- RMW_RD: mem_rd is captured into a merge register.
- WRITE, mem_wd:
  - SW: latched wdata.
  - SB: merge word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: merge word with halfword addr[1] replaced by wdata[15:0].
- Errors set resp_err = 1 and resp_rdata = 0. Error conditions:
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - load funct3 in {011, 110, 111};
  - store funct3 not in {000, 001, 010};
  - addr[31:2] >= MEM_WORDS.
- Reset asserted in any state:
  - returns to IDLE on that edge;
  - no write occurs in that cycle;
  - no resp_valid is produced for the aborted request.

Test Plan:
- Preload word 3 = 0x8899AABB; LB at 0x0000000D → resp_valid at cycle 2, resp_rdata = 0xFFFFFFAA, resp_err = 0.
- Same word; LHU at 0x0000000E → resp_rdata = 0x00008899; LW at 0x0C → 0x8899AABB.
- SB wdata = 0x00000055 at 0x0000000C → one mem_we pulse in cycle 2, word 3 becomes 0x8899AA55, resp_valid in cycle 3, resp_rdata = 0.
- LW at 0x00000006, then SH at 0x00000101 → each gives resp_err = 1 in cycle 1 with no mem_we. Then LW at 0x00000100 with MEM_WORDS = 64 → resp_err = 1.
- Back-to-back SW 0x12345678 at 0x10, then LW 0x10 with req_valid held high → second accept occurs after RESP, returns 0x12345678; req_ready is low during busy cycles.
- SH 0xBEEF at 0x12 with reset asserted in the RMW_RD cycle → no write, word 4 unchanged, no resp_valid, req_ready = 1 on the next cycle.
